// File: rtl/alu_operand_seq.sv
// alu_operand_seq: issue/writeback sequencer around a combinational ALU with an operand regfile.
// Define ALU_SEQ_FLAGS_EN to add the flag_z/flag_c outputs.
module alu_operand_seq #(
  parameter int n     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic          cmd_wr,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [n:0]    load_data,
  output logic [n:0]    alu_A,
  output logic [n:0]    alu_B,
  output logic [4:0]    alu_sel,
  input  logic [n:0]    alu_out,
  input  logic          alu_cout,
`ifdef ALU_SEQ_FLAGS_EN
  output logic          flag_z,
  output logic          flag_c,
`endif
  output logic          res_valid,
  output logic [n:0]    res_data,
  output logic          res_cout,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
  logic [1:0]    r_state;
  logic [n:0]    r_rf [DEPTH];
  logic [AW-1:0] r_rd;
  logic          r_wr;
  logic          w_accept;
  assign cmd_ready = (r_state == IDLE) & ~load_valid & ~reset;
  assign busy      = (r_state != IDLE) & ~reset;
  assign w_accept  = cmd_valid & cmd_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_sel   <= '0;
      r_rd      <= '0;
      r_wr      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
`endif
    end else begin
      r_state   <= r_state == EXEC ? WB : r_state == WB ? IDLE : w_accept ? EXEC : IDLE;
      res_valid <= r_state == WB;
      if (r_state == IDLE && load_valid) r_rf[load_addr] <= load_data;
      if (w_accept) begin
        alu_A   <= r_rf[cmd_ra];
        alu_B   <= r_rf[cmd_rb];
        alu_sel <= cmd_op;
        r_rd    <= cmd_rd;
        r_wr    <= cmd_wr;
      end
      if (r_state == WB) begin
        res_data <= alu_out;
        res_cout <= alu_cout;
        if (r_wr) r_rf[r_rd] <= alu_out;
`ifdef ALU_SEQ_FLAGS_EN
        flag_z   <= alu_out == '0;
        flag_c   <= alu_cout;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: scoreboard bench for alu_operand_seq with a small add/sub ALU model attached.
module tb_alu_operand_seq;
  logic        clock = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [4:0]  cmd_op = '0, alu_sel;
  logic [1:0]  cmd_ra = '0, cmd_rb = '0, cmd_rd = '0, load_addr = '0;
  logic        load_valid = 1'b0;
  logic [16:0] load_data = '0, alu_A, alu_B, alu_out, res_data;
  logic        alu_cout, res_valid, res_cout, busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z, flag_c;
`endif
  logic [17:0] w_sum;
  int checks = 0, errors = 0, cyc = 0, a1, a2, a3, dummy;
  logic prev_rv = 1'b0;
  typedef struct {logic [16:0] d; logic c; int cy;} exp_t;
  exp_t q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // op 0 = add with carry out, op 1 = subtract with borrow out
  always_comb begin
    w_sum = '0;
    if (alu_sel == 5'd0) w_sum = {1'b0, alu_A} + {1'b0, alu_B};
    else if (alu_sel == 5'd1) w_sum = {1'b0, alu_A} - {1'b0, alu_B};
  end
  assign alu_out  = w_sum[16:0];
  assign alu_cout = w_sum[17];

  alu_operand_seq dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_out(alu_out), .alu_cout(alu_cout),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_z(flag_z), .flag_c(flag_c),
`endif
    .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout), .busy(busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (res_valid) begin
      chk("res_valid_adjacent", {31'b0, prev_rv}, 32'd0);
      if (q.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", {15'b0, res_data}, {15'b0, e.d});
        chk("res_cout", {31'b0, res_cout}, {31'b0, e.c});
        chk("res_latency_cycle", cyc, e.cy);
      end
    end
    prev_rv = res_valid;
  end

  task automatic issue(input logic [4:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic wr, input logic push,
                       input logic [16:0] ed, input logic ec, output int acc);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_wr = wr; cmd_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = cyc + 1;
        if (push) q.push_back('{ed, ec, acc + 2});
        @(posedge clock); #1;
        return;
      end
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && q.size() != 0; t++) @(negedge clock);
    chk("drain_queue_empty", q.size(), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [16:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", {15'b0, res_data}, 32'd0);
    chk("rst_alu_A", {15'b0, alu_A}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clock); #1;
    // T1: add with writeback, then chained use of the written register
    load(2'd0, 17'd5); load(2'd1, 17'd3);
    issue(5'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 17'd8, 1'b0, dummy);
    @(negedge clock);
    chk("busy_in_exec", {31'b0, busy}, 32'd1);
    issue(5'd0, 2'd2, 2'd2, 2'd3, 1'b1, 1'b1, 17'd16, 1'b0, dummy);
    issue(5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 17'd32, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
    // T2: subtract with borrow, no writeback
    issue(5'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 17'h1FFFE, 1'b1, dummy);
    issue(5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 17'd10, 1'b0, dummy);
    issue(5'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, 17'd6, 1'b0, dummy);
    issue(5'd0, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 17'd16, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
    // T3: load wins over a simultaneous command, which then sees the new value
    load_valid = 1'b1; load_addr = 2'd1; load_data = 17'd100;
    cmd_op = 5'd0; cmd_ra = 2'd1; cmd_rb = 2'd0; cmd_rd = 2'd3; cmd_wr = 1'b1; cmd_valid = 1'b1;
    @(negedge clock);
    chk("ready_low_on_load", {31'b0, cmd_ready}, 32'd0);
    @(posedge clock); #1 load_valid = 1'b0;
    issue(5'd0, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1, 17'd105, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
    // T5: cmd_valid held high; load pulsed while busy must be ignored
    issue(5'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 17'd105, 1'b0, a1);
    fork
      begin
        load_valid = 1'b1; load_addr = 2'd0; load_data = 17'd999;
        @(posedge clock); @(posedge clock); #1 load_valid = 1'b0;
      end
    join_none
    issue(5'd0, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 17'd200, 1'b0, a2);
    issue(5'd1, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1, 17'd0, 1'b0, a3);
    cmd_valid = 1'b0;
    chk("b2b_spacing_1", a2 - a1, 32'd3);
    chk("b2b_spacing_2", a3 - a2, 32'd3);
    drain();
    issue(5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 17'd10, 1'b0, dummy);
    issue(5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 17'd210, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
    // T4: reset during EXEC aborts the command
    issue(5'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 17'd0, 1'b0, dummy);
    cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_mid_alu_A", {15'b0, alu_A}, 32'd0);
    chk("rst_mid_alu_B", {15'b0, alu_B}, 32'd0);
    chk("rst_mid_alu_sel", {27'b0, alu_sel}, 32'd0);
    chk("rst_mid_res_data", {15'b0, res_data}, 32'd0);
    chk("rst_mid_res_cout", {31'b0, res_cout}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("rst_mid_no_pulse", {31'b0, res_valid}, 32'd0);
    @(posedge clock); #1;
    issue(5'd0, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 17'd0, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
`ifdef ALU_SEQ_FLAGS_EN
    // T6: zero and carry flags
    load(2'd0, 17'd7); load(2'd1, 17'd7);
    issue(5'd1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 17'd0, 1'b0, dummy);
    cmd_valid = 1'b0; drain();
    chk("flag_z_sub", {31'b0, flag_z}, 32'd1);
    chk("flag_c_sub", {31'b0, flag_c}, 32'd0);
    load(2'd2, 17'h1FFFF); load(2'd3, 17'd1);
    issue(5'd0, 2'd2, 2'd3, 2'd0, 1'b0, 1'b1, 17'd0, 1'b1, dummy);
    cmd_valid = 1'b0; drain();
    chk("flag_z_add", {31'b0, flag_z}, 32'd1);
    chk("flag_c_add", {31'b0, flag_c}, 32'd1);
`endif
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
